// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one captured data register among NUM_REQ requesters, valid/ready output.
// Optional DFF_ARB_LOCK_EN: the last winner keeps the register while it holds both req and lock.
module dff_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 1,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         dout,
  output logic [IDX_W-1:0]          dout_id,
  output logic                      dout_valid,
  input  logic                      dout_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic              lock_hit;
  logic              accept;
  logic [DATA_W-1:0] win_data;

`ifdef DFF_ARB_LOCK_EN
  // Set once any requester has won; ptr then names the lock candidate.
  logic lock_owner_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_owner_vld <= 1'b0;
    end else if (accept) begin
      lock_owner_vld <= 1'b1;
    end
  end

  assign lock_hit = lock_owner_vld & req[ptr] & lock[ptr];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_hit    = 1'b0;
`endif

  assign accept     = ~rst & (|req) & ((state == EMPTY) | dout_ready);
  assign dout_valid = (state == FULL);

  // Scan upward from ptr+1 with wrap; first active request wins unless the lock holds.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    if (lock_hit) begin
      win_idx = ptr;
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = din[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    if (accept) begin
      gnt[win_idx] = 1'b1;
    end
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (dout_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      dout    <= '0;
      dout_id <= '0;
      ptr     <= IDX_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (accept) begin
        dout    <= win_data;
        dout_id <= win_idx;
        ptr     <= win_idx;
      end
    end
  end

endmodule
